// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM encoding,
// parameter defaults and counter widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned DEF_BRANCH_PENALTY = 2;
    localparam int unsigned DEF_MEM_TIMEOUT    = 255;

    localparam int unsigned STALL_W = 32;
    localparam int unsigned FLUSH_W = 16;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned FCNT_W  = 3;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush/memory-wait controller: drives stage enables and NOP
// insertion, and keeps stall, flush and memory-timeout statistics.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned BRANCH_PENALTY = DEF_BRANCH_PENALTY,
    parameter int unsigned MEM_TIMEOUT    = DEF_MEM_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               raw_hazard,
    input  logic               branch_taken,
    input  logic               dmem_req,
    input  logic               dmem_ready,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               id_ex_en,
    output logic               ex_mem_en,
    output logic               if_id_flush,
    output logic               id_ex_bubble,
    output logic               mem_wb_bubble,
    output logic               mem_timeout,
    output logic [STALL_W-1:0] stall_cycles,
    output logic [FLUSH_W-1:0] flush_events
);

    state_t              state;
    state_t              state_nx;
    logic [FCNT_W-1:0]   fcnt;
    logic [FCNT_W-1:0]   fcnt_nx;
    logic [WAIT_W-1:0]   wcnt;
    logic                mem_stall;
    logic                branch_acc;
    logic                stall_inc;

    assign mem_stall = dmem_req & ~dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
        end
    end

    // A memory stall freezes both the state and the flush countdown.
    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        case (state)
            INIT: begin
                state_nx = RUN;
            end
            RUN: begin
                if (!mem_stall && branch_taken && (BRANCH_PENALTY > 1)) begin
                    state_nx = FLUSH;
                    fcnt_nx  = FCNT_W'(BRANCH_PENALTY - 1);
                end
            end
            FLUSH: begin
                if (!mem_stall) begin
                    fcnt_nx = fcnt - 1'b1;
                    if (fcnt == FCNT_W'(1)) begin
                        state_nx = RUN;
                    end
                end
            end
            default: begin
                state_nx = INIT;
                fcnt_nx  = '0;
            end
        endcase
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        branch_acc    = 1'b0;
        if ((state != RUN) && (state != FLUSH)) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (state == FLUSH) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
        end else if (branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            branch_acc    = 1'b1;
        end else if (raw_hazard) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_bubble  = 1'b1;
        end
    end

    assign stall_inc = ((state == RUN) || (state == FLUSH)) && !pc_en;

    sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(FLUSH_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (branch_acc),
        .count (flush_events)
    );

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~mem_stall),
        .inc   (mem_stall),
        .count (wcnt)
    );

    // Set on the edge where wcnt becomes MEM_TIMEOUT so the flag appears with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout <= 1'b0;
        end else if (mem_stall && (wcnt >= WAIT_W'(MEM_TIMEOUT - 1))) begin
            mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned BP = 2;
    localparam int unsigned MT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        raw_hazard, branch_taken, dmem_req, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic        if_id_flush, id_ex_bubble, mem_wb_bubble, mem_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    int errors = 0;
    int checks = 0;

    // Model: pending INIT cycle, remaining forced flush cycles, statistics.
    bit      m_init;
    int      m_flush_left;
    longint  m_stall;
    int      m_flushes;
    int      m_wait;
    bit      m_timeout;

    always #5 clk = ~clk;

    pipe_ctrl #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raw_hazard    (raw_hazard),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_timeout   (mem_timeout),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble}.
    function automatic logic [6:0] model_ctrl(input bit raw, input bit br, input bit mstall);
        if (m_init)                 return 7'b0000_111;
        if (mstall)                 return 7'b0000_001;
        if (m_flush_left > 0 || br) return 7'b1111_110;
        if (raw)                    return 7'b0011_010;
        return 7'b1111_000;
    endfunction

    function automatic logic [6:0] dut_ctrl();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble};
    endfunction

    task automatic check_stats(input string tag);
        check({tag, ".stall"}, 64'(stall_cycles), 64'(m_stall));
        check({tag, ".flush"}, 64'(flush_events), 64'(m_flushes));
        check({tag, ".tmo"}, 64'(mem_timeout), 64'(m_timeout));
    endtask

    task automatic cycle(input bit raw, input bit br, input bit req, input bit rdy);
        bit mstall;
        @(negedge clk);
        raw_hazard   = raw;
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
        mstall       = req && !rdy;
        #1;
        check("ctrl", 64'(dut_ctrl()), 64'(model_ctrl(raw, br, mstall)));
        @(posedge clk);
        if (!m_init) begin
            if (mstall || (m_flush_left == 0 && !br && raw))
                m_stall = (m_stall < 64'hFFFF_FFFF) ? m_stall + 1 : m_stall;
            if (!mstall && m_flush_left > 0) begin
                m_flush_left--;
            end else if (!mstall && br) begin
                m_flushes    = (m_flushes < 16'hFFFF) ? m_flushes + 1 : m_flushes;
                m_flush_left = BP - 1;
            end
        end
        m_wait = mstall ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
        if (m_wait >= MT) m_timeout = 1;
        m_init = 0;
        #1;
        check_stats("stats");
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        m_init = 1; m_flush_left = 0; m_stall = 0; m_flushes = 0; m_wait = 0; m_timeout = 0;
        #1;
        check("rst.ctrl", 64'(dut_ctrl()), 64'(7'b0000_111));
        check_stats("rst");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        raw_hazard = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 0;
        @(posedge clk);
        apply_reset();

        // Reset release: one INIT cycle, then free-running.
        repeat (3) cycle(0, 0, 0, 0);

        // Three-cycle RAW hazard.
        repeat (3) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("raw3.stall", 64'(stall_cycles), 64'd3);

        // Branch wins over a concurrent hazard; flush window ignores the hazard.
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("br.flush", 64'(flush_events), 64'd1);
        check("br.stall", 64'(stall_cycles), 64'd3);

        // Branch held across a memory wait is taken once on the ready cycle.
        repeat (4) cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("memwait.flush", 64'(flush_events), 64'd2);

        // Timeout after the third wait cycle, sticky after ready.
        apply_reset();
        cycle(0, 0, 0, 0);
        repeat (2) cycle(0, 0, 1, 0);
        check("tmo.before", 64'(mem_timeout), 64'd0);
        cycle(0, 0, 1, 0);
        check("tmo.third", 64'(mem_timeout), 64'd1);
        repeat (2) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 0);
        check("tmo.sticky", 64'(mem_timeout), 64'd1);

        // Reset in the middle of a flush window.
        cycle(0, 1, 0, 0);
        apply_reset();
        repeat (3) cycle(0, 0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 2) apply_reset();
            cycle($urandom_range(99) < 30, $urandom_range(99) < 15,
                  $urandom_range(99) < 35, $urandom_range(99) < 60);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter BRANCH_PENALTY, default 2, range 1-7: cycles IF/ID is flushed after a taken branch.
REQ-002 Parameter MEM_TIMEOUT, default 255, range 1-255: data-memory wait cycles before the sticky timeout error.
REQ-003 clk  in  1  single clock; every register samples on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 raw_hazard  in  1  RAW hazard request from the hazard unit: stall IF/ID and bubble ID/EX.
REQ-006 branch_taken  in  1  taken branch or jump resolved in EX.
REQ-007 dmem_req  in  1  load or store valid in MEM.
REQ-008 dmem_ready  in  1  data memory completes the current access this cycle.
REQ-009 pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  stage register enables.
REQ-010 if_id_flush, id_ex_bubble, mem_wb_bubble  out  1 each  insert a NOP into that stage register.
REQ-011 mem_timeout  out  1  sticky error flag.
REQ-012 stall_cycles  out  32  saturating count of cycles with pc_en=0 in RUN or FLUSH.
REQ-013 flush_events  out  16  saturating count of accepted taken branches.

Function
REQ-014 FSM states: INIT, RUN, FLUSH. Reset enters INIT. INIT lasts exactly one cycle, then moves to RUN.
REQ-015 INIT outputs: all enables 0; if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1.
REQ-016 mem_stall = dmem_req & ~dmem_ready. It is combinational and has highest priority in RUN and FLUSH.
REQ-017 While mem_stall is high:
- pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
- mem_wb_bubble = 1.
- if_id_flush = 0, id_ex_bubble = 0.
- The FSM state and the FLUSH counter hold.
REQ-018 In RUN with no mem_stall, branch_taken=1 (takes priority over raw_hazard):
- pc_en=1, if_id_flush=1, id_ex_bubble=1, other enables 1.
- flush_events increments.
- If BRANCH_PENALTY>1: go to FLUSH, load fcnt=BRANCH_PENALTY-1. Otherwise stay in RUN.
REQ-019 In RUN with no mem_stall, no branch, raw_hazard=1:
- pc_en=0, if_id_en=0, id_ex_bubble=1.
- ex_mem_en=1, id_ex_en=1, if_id_flush=0.
REQ-020 In RUN with no stall, branch or hazard: all enables 1, all bubble/flush outputs 0.
REQ-021 In FLUSH with no mem_stall:
- if_id_flush=1, id_ex_bubble=1, pc_en=1, other enables 1.
- raw_hazard and branch_taken are ignored.
- fcnt decrements each cycle; at fcnt==1 the next state is RUN.
REQ-022 A branch_taken held high through a mem_stall is acted on only in the first non-stalled cycle, and is counted once.
REQ-023 Wait counter wcnt (8 bits):
- clears on any cycle with mem_stall=0.
- increments while mem_stall=1, saturating at 255.
- mem_timeout sets when wcnt reaches MEM_TIMEOUT and stays set until reset.
REQ-024 stall_cycles and flush_events saturate at all-ones and never wrap. stall_cycles counts raw-hazard and mem_stall cycles.
REQ-025 All enable, bubble and flush outputs are combinational from the state and current inputs. Counters and mem_timeout are registered, with 1-cycle latency to the output.

Reset
REQ-026 While rst_n=0:
- state=INIT, fcnt=0, wcnt=0.
- stall_cycles=0, flush_events=0, mem_timeout=0.
- Outputs take the INIT values of REQ-015.
REQ-027 Reset asserted mid-FLUSH or mid-mem-wait aborts immediately. There is no residual flush or stall after release beyond the single INIT cycle.

Structure
REQ-028 Shared package pipe_pkg holds:
- the state encoding (INIT/RUN/FLUSH);
- default BRANCH_PENALTY and MEM_TIMEOUT constants;
- counter widths.
REQ-029 One sub-module, sat_counter (parameterised width, inc, clr, async active-low reset), instantiated for stall_cycles, flush_events and wcnt.

Verification
REQ-030 Release reset, all inputs 0 -> cycle 0: INIT outputs; cycle 1 onward: all enables 1, all bubbles 0.
REQ-031 raw_hazard=1 for 3 cycles in RUN -> pc_en=0 and id_ex_bubble=1 for exactly 3 cycles; stall_cycles=3 one cycle later.
REQ-032 BRANCH_PENALTY=2, branch_taken pulse in RUN with raw_hazard=1 ->
- if_id_flush=1 for 2 consecutive cycles and pc_en=1 throughout;
- flush_events=1; stall_cycles unchanged.
REQ-033 dmem_req=1, dmem_ready=0 for 4 cycles, branch_taken=1 throughout, then ready=1 ->
- 4 frozen cycles with mem_wb_bubble=1;
- branch accepted once on the ready cycle; flush_events=1.
REQ-034 MEM_TIMEOUT=3, dmem_ready=0 for 5 cycles -> mem_timeout=1 after the 3rd wait cycle; still 1 after ready returns.
REQ-035 Reset asserted mid-FLUSH (fcnt=1) ->
- immediately INIT outputs and all counters 0;
- after release, one INIT cycle then RUN with no flush.
